id_stage: RTL and testbench
===========================

Name: id_stage

Overview:
- RV64I decode stage sitting directly upstream of the execute-stage ALU.
- Accepts one fetched instruction per cycle over a valid/ready handshake and decodes it into the ALU's 17-bit one-hot control word plus both operands.
- Reads the register file combinationally.
- Holds the result in an ID/EX pipeline register with valid/ready backpressure and a flush input.

Parameters:
XLEN, 64, datapath width (fixed at 64; the parameter exists for documentation and lint).
CTRL_W, 17, one-hot ALU control width.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept this cycle
in_instr  input  32  instruction word
in_pc  input  64  instruction address
flush  input  1  kill the held instruction; block acceptance this cycle
rf_raddr1  output  5  = in_instr[19:15], combinational
rf_raddr2  output  5  = in_instr[24:20], combinational
rf_rdata1  input  64  register file data, same cycle
rf_rdata2  input  64  register file data, same cycle
out_valid  output  1  ID/EX register holds a valid instruction
out_ready  input  1  EX consumes this cycle
out_alu_ctrl  output  17  one-hot: bit0 add, 1 sub, 2 slt, 3 sltu, 4 and, 5 xor, 6 or, 7 sll, 8 srl, 9 sra, 10 lui, 11 beq, 12 bne, 13 blt, 14 bge, 15 bltu, 16 bgeu
out_alu_sr1  output  64  ALU operand 1
out_alu_sr2  output  64  ALU operand 2
out_rd  output  5  destination register
out_rd_wen  output  1  writes rd; 0 for branches, illegal instructions, and rd==0
out_br_target  output  64  in_pc + sign-extended B-immediate
out_pc  output  64  pc of the held instruction
out_illegal  output  1  unsupported encoding

Behaviour:
- Reset (async, rst=1): out_valid=0 and every other registered output=0. in_ready follows its formula, i.e. 1 while out_valid=0.
- in_ready = ~out_valid | out_ready. Purely combinational; no dependency on in_valid.
- Accept when in_valid & in_ready & ~flush. On the next edge all out_* are loaded and out_valid=1. Decode-to-output latency is 1 cycle.
- If out_valid & out_ready & ~(accept): out_valid goes to 0 next edge. Data registers may hold stale values.
- Registers are stable while out_valid & ~out_ready.
- flush=1: out_valid goes to 0 next edge, regardless of in_valid or out_ready. A simultaneous in_valid is dropped.
- Decode:
  - OP (0110011): funct3/funct7 select add/sub/sll/slt/sltu/xor/srl/sra/or/and. sr1=rdata1, sr2=rdata2. For sll/srl/sra, sr2={58'b0, rdata2[5:0]}.
  - OP-IMM (0010011): addi/slti/sltiu/xori/ori/andi use sr2=sext(I-imm). slli/srli/srai use sr2={58'b0, instr[25:20]}. funct6 must be 000000 (010000 for srai), otherwise illegal.
  - LUI (0110111): op lui; sr2=sext({instr[31:12],12'b0}); sr1=0.
  - AUIPC (0010111): op add; sr1=in_pc; sr2=sext(U-imm).
  - BRANCH (1100011): funct3 000/001/100/101/110/111 map to beq/bne/blt/bge/bltu/bgeu. sr1=rdata1, sr2=rdata2. rd_wen=0. funct3 010/011 is illegal.
  - Any other opcode, or an invalid funct7/funct3: out_illegal=1, alu_ctrl=0, rd_wen=0, operands=0.
- out_alu_ctrl has exactly one bit set for every legal instruction.
- out_rd_wen is forced to 0 when rd==0.
- Immediates sign-extend from instr[31]. All address and immediate arithmetic wraps modulo 2^64.
- Reset asserted mid-handshake: the held instruction is discarded and nothing is replayed.

Test Plan:
- addi x1,x2,-1 (0xFFF10093) with rdata1=5 -> next cycle out_valid=1, alu_ctrl=0x00001, sr1=5, sr2=0xFFFFFFFFFFFFFFFF, rd=1, rd_wen=1.
- sub x3,x1,x2 (0x402081B3) -> alu_ctrl=0x00002. Then slli x5,x6,63 (0x03F31293) -> alu_ctrl=0x00080, sr2=63. Then sll with rdata2=0x1C1 -> sr2=1.
- lui x7,0x80000 (0x800003B7) -> alu_ctrl=0x00400, sr2=0xFFFFFFFF80000000. Then bgeu x1,x2,-4 at pc 0x100 (0xFE20FEE3) -> alu_ctrl=0x10000, rd_wen=0, br_target=0xFC.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged. Raise out_ready -> the next instruction loads on the following edge with no loss or duplication.
- flush=1 with in_valid=1 and out_valid=1 -> out_valid=0 next cycle and the input is not captured. Opcode 0000011 -> out_illegal=1, alu_ctrl=0.
- Assert rst mid-stream -> out_valid and all outputs 0 immediately, without waiting for a clock edge. in_ready=1 while reset is held.

Source files
------------

// File: rtl/id_stage.sv
// RV64I decode stage feeding the execute ALU.
// Decodes one instruction per cycle and holds it in the ID/EX register.
// The ID/EX register has valid/ready backpressure and a flush input.
module id_stage #(
   parameter int XLEN   = 64,
   parameter int CTRL_W = 17
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [31:0]       in_instr,
   input  logic [XLEN-1:0]   in_pc,
   input  logic              flush,
   output logic [4:0]        rf_raddr1,
   output logic [4:0]        rf_raddr2,
   input  logic [XLEN-1:0]   rf_rdata1,
   input  logic [XLEN-1:0]   rf_rdata2,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_alu_ctrl,
   output logic [XLEN-1:0]   out_alu_sr1,
   output logic [XLEN-1:0]   out_alu_sr2,
   output logic [4:0]        out_rd,
   output logic              out_rd_wen,
   output logic [XLEN-1:0]   out_br_target,
   output logic [XLEN-1:0]   out_pc,
   output logic              out_illegal
);

   localparam int C_ADD  = 0;
   localparam int C_SUB  = 1;
   localparam int C_SLT  = 2;
   localparam int C_SLTU = 3;
   localparam int C_AND  = 4;
   localparam int C_XOR  = 5;
   localparam int C_OR   = 6;
   localparam int C_SLL  = 7;
   localparam int C_SRL  = 8;
   localparam int C_SRA  = 9;
   localparam int C_LUI  = 10;
   localparam int C_BEQ  = 11;
   localparam int C_BNE  = 12;
   localparam int C_BLT  = 13;
   localparam int C_BGE  = 14;
   localparam int C_BLTU = 15;
   localparam int C_BGEU = 16;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   logic              valid_q, valid_d;
   logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
   logic [XLEN-1:0]   sr1_q, sr1_d;
   logic [XLEN-1:0]   sr2_q, sr2_d;
   logic [4:0]        rd_q, rd_d;
   logic              rd_wen_q, rd_wen_d;
   logic [XLEN-1:0]   br_target_q, br_target_d;
   logic [XLEN-1:0]   pc_q, pc_d;
   logic              illegal_q, illegal_d;

   logic              accept;
   logic [6:0]        opcode;
   logic [2:0]        funct3;
   logic [6:0]        funct7;
   logic [5:0]        funct6;
   logic [XLEN-1:0]   imm_i, imm_u, imm_b;
   logic [XLEN-1:0]   dec_sr1, dec_sr2;
   logic [CTRL_W-1:0] dec_ctrl;
   logic              dec_illegal, dec_branch;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign funct6 = in_instr[31:26];
   assign imm_i  = {{52{in_instr[31]}}, in_instr[31:20]};
   assign imm_u  = {{32{in_instr[31]}}, in_instr[31:12], 12'b0};
   assign imm_b  = {{51{in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};

   assign rf_raddr1 = in_instr[19:15];
   assign rf_raddr2 = in_instr[24:20];

   assign in_ready = ~valid_q | out_ready;
   assign accept   = in_valid & in_ready & ~flush;

   // Instruction decode: one-hot ALU control, operand selection, legality.
   always_comb begin
      dec_ctrl    = '0;
      dec_sr1     = '0;
      dec_sr2     = '0;
      dec_illegal = 1'b0;
      dec_branch  = 1'b0;
      unique case (opcode)
         OPC_OP: begin
            dec_sr1 = rf_rdata1;
            dec_sr2 = rf_rdata2;
            if (funct7 == 7'b0000000) begin
               unique case (funct3)
                  3'b000: dec_ctrl[C_ADD]  = 1'b1;
                  3'b001: dec_ctrl[C_SLL]  = 1'b1;
                  3'b010: dec_ctrl[C_SLT]  = 1'b1;
                  3'b011: dec_ctrl[C_SLTU] = 1'b1;
                  3'b100: dec_ctrl[C_XOR]  = 1'b1;
                  3'b101: dec_ctrl[C_SRL]  = 1'b1;
                  3'b110: dec_ctrl[C_OR]   = 1'b1;
                  default: dec_ctrl[C_AND] = 1'b1;
               endcase
            end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
               dec_ctrl[C_SUB] = 1'b1;
            end else if (funct7 == 7'b0100000 && funct3 == 3'b101) begin
               dec_ctrl[C_SRA] = 1'b1;
            end else begin
               dec_illegal = 1'b1;
            end
            // RV64 shifts use only the low six bits of the shift amount
            if (funct3 == 3'b001 || funct3 == 3'b101)
               dec_sr2 = {58'b0, rf_rdata2[5:0]};
         end
         OPC_OPIMM: begin
            dec_sr1 = rf_rdata1;
            dec_sr2 = imm_i;
            unique case (funct3)
               3'b000: dec_ctrl[C_ADD]  = 1'b1;
               3'b010: dec_ctrl[C_SLT]  = 1'b1;
               3'b011: dec_ctrl[C_SLTU] = 1'b1;
               3'b100: dec_ctrl[C_XOR]  = 1'b1;
               3'b110: dec_ctrl[C_OR]   = 1'b1;
               3'b111: dec_ctrl[C_AND]  = 1'b1;
               3'b001: begin
                  dec_sr2 = {58'b0, in_instr[25:20]};
                  if (funct6 == 6'b000000) dec_ctrl[C_SLL] = 1'b1;
                  else                     dec_illegal     = 1'b1;
               end
               default: begin
                  dec_sr2 = {58'b0, in_instr[25:20]};
                  if (funct6 == 6'b000000)      dec_ctrl[C_SRL] = 1'b1;
                  else if (funct6 == 6'b010000) dec_ctrl[C_SRA] = 1'b1;
                  else                          dec_illegal     = 1'b1;
               end
            endcase
         end
         OPC_LUI: begin
            dec_ctrl[C_LUI] = 1'b1;
            dec_sr2         = imm_u;
         end
         OPC_AUIPC: begin
            dec_ctrl[C_ADD] = 1'b1;
            dec_sr1         = in_pc;
            dec_sr2         = imm_u;
         end
         OPC_BRANCH: begin
            dec_branch = 1'b1;
            dec_sr1    = rf_rdata1;
            dec_sr2    = rf_rdata2;
            unique case (funct3)
               3'b000: dec_ctrl[C_BEQ]  = 1'b1;
               3'b001: dec_ctrl[C_BNE]  = 1'b1;
               3'b100: dec_ctrl[C_BLT]  = 1'b1;
               3'b101: dec_ctrl[C_BGE]  = 1'b1;
               3'b110: dec_ctrl[C_BLTU] = 1'b1;
               3'b111: dec_ctrl[C_BGEU] = 1'b1;
               default: dec_illegal     = 1'b1;
            endcase
         end
         default: dec_illegal = 1'b1;
      endcase
      // Illegal encodings present a fully zeroed control/operand set to EX
      if (dec_illegal) begin
         dec_ctrl = '0;
         dec_sr1  = '0;
         dec_sr2  = '0;
      end
   end

   // ID/EX next-state: flush wins, then accept, then drain on consume.
   always_comb begin
      valid_d     = valid_q;
      alu_ctrl_d  = alu_ctrl_q;
      sr1_d       = sr1_q;
      sr2_d       = sr2_q;
      rd_d        = rd_q;
      rd_wen_d    = rd_wen_q;
      br_target_d = br_target_q;
      pc_d        = pc_q;
      illegal_d   = illegal_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (accept) begin
         valid_d     = 1'b1;
         alu_ctrl_d  = dec_ctrl;
         sr1_d       = dec_sr1;
         sr2_d       = dec_sr2;
         rd_d        = in_instr[11:7];
         rd_wen_d    = ~dec_illegal & ~dec_branch & (in_instr[11:7] != 5'd0);
         br_target_d = in_pc + imm_b;
         pc_d        = in_pc;
         illegal_d   = dec_illegal;
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // ID/EX register; reset discards any held instruction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q     <= 1'b0;
         alu_ctrl_q  <= '0;
         sr1_q       <= '0;
         sr2_q       <= '0;
         rd_q        <= '0;
         rd_wen_q    <= 1'b0;
         br_target_q <= '0;
         pc_q        <= '0;
         illegal_q   <= 1'b0;
      end else begin
         valid_q     <= valid_d;
         alu_ctrl_q  <= alu_ctrl_d;
         sr1_q       <= sr1_d;
         sr2_q       <= sr2_d;
         rd_q        <= rd_d;
         rd_wen_q    <= rd_wen_d;
         br_target_q <= br_target_d;
         pc_q        <= pc_d;
         illegal_q   <= illegal_d;
      end
   end

   assign out_valid     = valid_q;
   assign out_alu_ctrl  = alu_ctrl_q;
   assign out_alu_sr1   = sr1_q;
   assign out_alu_sr2   = sr2_q;
   assign out_rd        = rd_q;
   assign out_rd_wen    = rd_wen_q;
   assign out_br_target = br_target_q;
   assign out_pc        = pc_q;
   assign out_illegal   = illegal_q;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage with hand-computed expectations.
module tb_id_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [63:0] in_pc;
   logic        flush;
   logic [4:0]  rf_raddr1, rf_raddr2;
   logic [63:0] rf_rdata1, rf_rdata2;
   logic        out_valid;
   logic        out_ready;
   logic [16:0] out_alu_ctrl;
   logic [63:0] out_alu_sr1, out_alu_sr2;
   logic [4:0]  out_rd;
   logic        out_rd_wen;
   logic [63:0] out_br_target, out_pc;
   logic        out_illegal;

   int n_vec = 0;
   int n_mis = 0;

   id_stage dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
      .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_alu_ctrl(out_alu_ctrl),
      .out_alu_sr1(out_alu_sr1), .out_alu_sr2(out_alu_sr2),
      .out_rd(out_rd), .out_rd_wen(out_rd_wen),
      .out_br_target(out_br_target), .out_pc(out_pc),
      .out_illegal(out_illegal)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present one instruction for a single edge, then sample just after it.
   task automatic send(input logic [31:0] instr, input logic [63:0] pc,
                       input logic [63:0] r1, input logic [63:0] r2);
      in_instr  = instr;
      in_pc     = pc;
      rf_rdata1 = r1;
      rf_rdata2 = r2;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid  = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
      rf_rdata1 = '0; rf_rdata2 = '0; out_ready = 1'b1;
      #12;
      chk("rst_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_ctrl", out_alu_ctrl, 0);
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;

      // addi x1,x2,-1
      in_instr = 32'hFFF10093; #1;
      chk("addi_raddr1", rf_raddr1, 2);
      send(32'hFFF10093, 64'h0, 64'd5, 64'd0);
      chk("addi_valid", out_valid, 1);
      chk("addi_ctrl", out_alu_ctrl, 17'h00001);
      chk("addi_sr1", out_alu_sr1, 64'd5);
      chk("addi_sr2", out_alu_sr2, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("addi_rd", out_rd, 1);
      chk("addi_wen", out_rd_wen, 1);

      // sub x3,x1,x2
      send(32'h402081B3, 64'h4, 64'd10, 64'd3);
      chk("sub_ctrl", out_alu_ctrl, 17'h00002);
      chk("sub_sr2", out_alu_sr2, 64'd3);
      chk("sub_rd", out_rd, 3);

      // slli x5,x6,63
      send(32'h03F31293, 64'h8, 64'd1, 64'd0);
      chk("slli_ctrl", out_alu_ctrl, 17'h00080);
      chk("slli_sr2", out_alu_sr2, 64'd63);

      // sll x1,x2,x3 with rdata2=0x1C1 -> shift amount 1
      send(32'h003110B3, 64'hC, 64'd7, 64'h1C1);
      chk("sll_ctrl", out_alu_ctrl, 17'h00080);
      chk("sll_sr2", out_alu_sr2, 64'd1);

      // srai x1,x2,5
      send(32'h40515093, 64'h10, 64'd9, 64'd0);
      chk("srai_ctrl", out_alu_ctrl, 17'h00200);
      chk("srai_sr2", out_alu_sr2, 64'd5);

      // slli with bad funct6 -> illegal
      send(32'h40511093, 64'h14, 64'd9, 64'd0);
      chk("badslli_ill", out_illegal, 1);
      chk("badslli_ctrl", out_alu_ctrl, 0);

      // lui x7,0x80000
      send(32'h800003B7, 64'h18, 64'd123, 64'd0);
      chk("lui_ctrl", out_alu_ctrl, 17'h00400);
      chk("lui_sr1", out_alu_sr1, 0);
      chk("lui_sr2", out_alu_sr2, 64'hFFFF_FFFF_8000_0000);
      chk("lui_wen", out_rd_wen, 1);

      // auipc x2,0x1 at pc 0x1000
      send(32'h00001117, 64'h1000, 64'd0, 64'd0);
      chk("auipc_ctrl", out_alu_ctrl, 17'h00001);
      chk("auipc_sr1", out_alu_sr1, 64'h1000);
      chk("auipc_sr2", out_alu_sr2, 64'h1000);

      // bgeu x1,x2,-4 at pc 0x100
      send(32'hFE20FEE3, 64'h100, 64'd4, 64'd8);
      chk("bgeu_ctrl", out_alu_ctrl, 17'h10000);
      chk("bgeu_wen", out_rd_wen, 0);
      chk("bgeu_tgt", out_br_target, 64'hFC);
      chk("bgeu_pc", out_pc, 64'h100);
      chk("bgeu_sr2", out_alu_sr2, 64'd8);

      // Load opcode unsupported
      send(32'h00003083, 64'h104, 64'd1, 64'd1);
      chk("ld_ill", out_illegal, 1);
      chk("ld_ctrl", out_alu_ctrl, 0);
      chk("ld_wen", out_rd_wen, 0);
      chk("ld_sr1", out_alu_sr1, 0);

      // Backpressure: A held (rd=3) while B (rd=5) waits
      send(32'h402081B3, 64'h200, 64'd1, 64'd2);
      out_ready = 1'b0;
      in_instr = 32'h03F31293; in_pc = 64'h204; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_in_ready", in_ready, 0);
         @(posedge clk); #1;
         chk("bp_rd_hold", out_rd, 3);
         chk("bp_pc_hold", out_pc, 64'h200);
      end
      out_ready = 1'b1; #1;
      chk("bp_release_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("bp_b_rd", out_rd, 5);
      chk("bp_b_pc", out_pc, 64'h204);
      chk("bp_b_valid", out_valid, 1);
      @(posedge clk); #1;
      chk("bp_no_dup", out_valid, 0);

      // Flush with simultaneous in_valid
      send(32'hFFF10093, 64'h300, 64'd5, 64'd0);
      chk("fl_pre_valid", out_valid, 1);
      out_ready = 1'b0;
      flush = 1'b1;
      in_instr = 32'h800003B7; in_pc = 64'h304; in_valid = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      chk("fl_valid", out_valid, 0);
      @(posedge clk); #1;
      chk("fl_not_captured", out_valid, 0);
      chk("fl_pc_kept", out_pc, 64'h300);

      // Asynchronous reset mid-stream
      send(32'h800003B7, 64'h400, 64'd0, 64'd0);
      chk("ar_pre_valid", out_valid, 1);
      out_ready = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("ar_valid", out_valid, 0);
      chk("ar_ctrl", out_alu_ctrl, 0);
      chk("ar_pc", out_pc, 0);
      chk("ar_sr2", out_alu_sr2, 0);
      chk("ar_in_ready", in_ready, 1);
      @(negedge clk); rst = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("ar_no_replay", out_valid, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

endmodule
